// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the front end.
//   ADDR_W / WIDTH_W : default PC width (in words) and instruction width
//   fetch_state_e    : fetch sequencer states
//   fetch_entry_t    : one buffered fetch, instruction plus the PC it came from
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int WIDTH_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [WIDTH_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO holding returned fetches.
//   clk, rst_n : clock, asynchronous active-low reset (storage clears to 0)
//   push/wdata : write an entry at the tail
//   pop        : drop the head entry (caller guarantees count != 0)
//   flush      : discard all entries; wins over push and pop
//   rdata      : head entry
//   count      : occupancy, 0..2 (caller guarantees no push when full
//                unless a pop happens in the same cycle)
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     wdata,
    output entry_t     rdata,
    output logic [1:0] count
);

    entry_t mem_q [2];
    logic   wr_ptr;
    logic   rd_ptr;

    assign rdata = mem_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= wdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch in front of a 1-cycle-latency SRAM.
//   clk, rst_n             : clock, asynchronous active-low reset
//   fetch_en               : permits issuing new reads
//   redirect_valid/_pc     : one-cycle branch/jump; loads pc and flushes everything
//   mem_cs/we/addr/wdata   : SRAM request side (read only; we and wdata tied low)
//   mem_rdata              : SRAM read data, valid the cycle after mem_cs
//   instr_valid/ready      : handshake to decode
//   instr, instr_pc        : head instruction and its PC
// Reads are only issued when the buffer is guaranteed room for the reply, so
// count + inflight never exceeds 2 and the SRAM never needs to be stalled.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              ADDR     = ADDR_W,
    parameter int              WIDTH    = WIDTH_W,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [ADDR-1:0]  redirect_pc,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [ADDR-1:0]  instr_pc
);

    typedef struct packed {
        logic [ADDR-1:0]  pc;
        logic [WIDTH-1:0] instr;
    } entry_t;

    fetch_state_e    state_q, state_d;
    logic [ADDR-1:0] pc_q;
    logic [ADDR-1:0] tag_q;     // PC of the read currently in flight
    logic            inflight_q;
    logic            issue;
    logic            pop;
    logic            push;
    logic [1:0]      count;
    logic [2:0]      credit;
    entry_t          head;
    entry_t          tail_in;

    // A redirect hides the head so decode cannot consume a stale instruction.
    assign instr_valid = (count != 2'd0) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;
    assign credit      = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    // The reply in flight is killed by a redirect in the cycle it returns.
    assign push        = inflight_q & ~redirect_valid;

    assign mem_cs    = issue;
    assign mem_we    = 1'b0;
    assign mem_addr  = pc_q;
    assign mem_wdata = '0;

    assign tail_in  = '{pc: tag_q, instr: mem_rdata};
    assign instr    = head.instr;
    assign instr_pc = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_en) state_d = RUN;
            end
            RUN: begin
                issue = fetch_en & ~redirect_valid & (credit < 3'd2);
                // Stay in RUN until the last reply has landed.
                if (!fetch_en && !inflight_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q  <= pc_q + 1'b1;
                tag_q <= pc_q;
            end
        end
    end

    fetch_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (tail_in),
        .rdata (head),
        .count (count)
    );

endmodule
